// File: rtl/alu_issue_stage_if.sv
// Bundle between decode, hazard unit, forwarding sources and the ALU issue stage.
// The master drives ID/hazard/forward inputs; the slave (issue stage) returns final ALU operands.
interface alu_issue_stage_if #(
    parameter int N = 32
);
    logic           stall_e;
    logic           flush_e;
    logic           valid_d;
    logic [1:0]     aluop_d;
    logic [5:0]     funct_d;
    logic           alusrc_d;
    logic [N-1:0]   rd1_d;
    logic [N-1:0]   rd2_d;
    logic [N-1:0]   signimm_d;
    logic [1:0]     forwardae_e;
    logic [1:0]     forwardbe_e;
    logic [N-1:0]   aluout_m;
    logic [N-1:0]   result_w;
    logic           valid_e;
    logic [2:0]     alucontrol_e;
    logic [N-1:0]   srca_e;
    logic [N-1:0]   srcb_e;
    logic [N-1:0]   writedata_e;
    logic           illegal_e;

    modport master (
        output stall_e, flush_e, valid_d, aluop_d, funct_d, alusrc_d,
               rd1_d, rd2_d, signimm_d, forwardae_e, forwardbe_e,
               aluout_m, result_w,
        input  valid_e, alucontrol_e, srca_e, srcb_e, writedata_e, illegal_e
    );

    modport slave (
        input  stall_e, flush_e, valid_d, aluop_d, funct_d, alusrc_d,
               rd1_d, rd2_d, signimm_d, forwardae_e, forwardbe_e,
               aluout_m, result_w,
        output valid_e, alucontrol_e, srca_e, srcb_e, writedata_e, illegal_e
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: ALU control decode, EX pipeline register, and EX operand forwarding.
// Optional macro ALU_NEGOPS_EN enables the inverted-B and/or funct codes (ALU codes 100/101).
module alu_issue_stage #(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_issue_stage_if.slave     bus
);

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;
`ifdef ALU_NEGOPS_EN
    localparam logic [2:0] ALU_ANDN = 3'b100;
    localparam logic [2:0] ALU_ORN  = 3'b101;
`endif

    // Returns {illegal, alucontrol}; unsupported codes fall back to add so the ALU stays benign.
    function automatic logic [3:0] decode_alu(input logic [1:0] aluop, input logic [5:0] funct);
        logic [3:0] v;
        case (aluop)
            2'b00: v = {1'b0, ALU_ADD};
            2'b01: v = {1'b0, ALU_SUB};
            2'b11: v = {1'b0, ALU_OR};
            2'b10: begin
                case (funct)
                    6'b100000: v = {1'b0, ALU_ADD};
                    6'b100010: v = {1'b0, ALU_SUB};
                    6'b100100: v = {1'b0, ALU_AND};
                    6'b100101: v = {1'b0, ALU_OR};
                    6'b101010: v = {1'b0, ALU_SLT};
`ifdef ALU_NEGOPS_EN
                    6'b110100: v = {1'b0, ALU_ANDN};
                    6'b110101: v = {1'b0, ALU_ORN};
`endif
                    default:   v = {1'b1, ALU_ADD};
                endcase
            end
            default: v = {1'b1, ALU_ADD};
        endcase
        return v;
    endfunction

    // 00 and 11 both select the registered operand.
    function automatic logic [N-1:0] fwd_mux(input logic [1:0] sel, input logic [N-1:0] rd,
                                             input logic [N-1:0] res_w, input logic [N-1:0] alu_m);
        logic [N-1:0] v;
        case (sel)
            2'b01:   v = res_w;
            2'b10:   v = alu_m;
            default: v = rd;
        endcase
        return v;
    endfunction

    logic [3:0]     w_dec;
    logic [2:0]     w_ctrl_d;
    logic           w_ill_d;

    logic           r_valid;
    logic [2:0]     r_ctrl;
    logic           r_ill;
    logic           r_alusrc;
    logic [N-1:0]   r_rd1;
    logic [N-1:0]   r_rd2;
    logic [N-1:0]   r_imm;

    logic [N-1:0]   w_srca;
    logic [N-1:0]   w_srcb;
    logic [N-1:0]   w_wd;

    // ID-side decode; an empty slot always carries a legal add.
    always_comb begin
        w_dec    = decode_alu(bus.aluop_d, bus.funct_d);
        w_ctrl_d = ALU_ADD;
        w_ill_d  = 1'b0;
        if (bus.valid_d) begin
            w_ctrl_d = w_dec[2:0];
            w_ill_d  = w_dec[3];
        end else begin
            w_ctrl_d = ALU_ADD;
            w_ill_d  = 1'b0;
        end
    end

    // EX pipeline register: reset and flush insert a bubble and win over stall.
    always_ff @(posedge clk) begin
        if (reset || bus.flush_e) begin
            r_valid  <= 1'b0;
            r_ctrl   <= ALU_ADD;
            r_ill    <= 1'b0;
            r_alusrc <= 1'b0;
            r_rd1    <= {N{1'b0}};
            r_rd2    <= {N{1'b0}};
            r_imm    <= {N{1'b0}};
        end else if (bus.stall_e) begin
            r_valid  <= r_valid;
            r_ctrl   <= r_ctrl;
            r_ill    <= r_ill;
            r_alusrc <= r_alusrc;
            r_rd1    <= r_rd1;
            r_rd2    <= r_rd2;
            r_imm    <= r_imm;
        end else begin
            r_valid  <= bus.valid_d;
            r_ctrl   <= w_ctrl_d;
            r_ill    <= w_ill_d;
            r_alusrc <= bus.alusrc_d;
            r_rd1    <= bus.rd1_d;
            r_rd2    <= bus.rd2_d;
            r_imm    <= bus.signimm_d;
        end
    end

    // Forwarding uses live selects so a stalled instruction still sees the newest results.
    always_comb begin
        w_srca = fwd_mux(bus.forwardae_e, r_rd1, bus.result_w, bus.aluout_m);
        w_wd   = fwd_mux(bus.forwardbe_e, r_rd2, bus.result_w, bus.aluout_m);
        w_srcb = w_wd;
        if (r_alusrc) begin
            w_srcb = r_imm;
        end else begin
            w_srcb = w_wd;
        end
    end

    assign bus.valid_e      = r_valid;
    assign bus.alucontrol_e = r_ctrl;
    assign bus.illegal_e    = r_ill;
    assign bus.srca_e       = w_srca;
    assign bus.srcb_e       = w_srcb;
    assign bus.writedata_e  = w_wd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed scoreboard bench for alu_issue_stage: a driver queues hand-computed EX views,
// a negedge monitor pops and compares them.
module tb_alu_issue_stage;

    logic clk;
    logic reset;

    alu_issue_stage_if #(.N(32)) bus ();

    alu_issue_stage #(.N(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        v;
        logic [1:0]  op;
        logic [5:0]  fn;
        logic        src;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
    } id_t;

    typedef struct {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] am;
        logic [31:0] rw;
    } fw_t;

    typedef struct {
        string       name;
        logic        v;
        logic [2:0]  ctrl;
        logic        ill;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] wd;
    } exp_t;

`ifdef ALU_NEGOPS_EN
    localparam logic [2:0] NEG_AND = 3'b100;
    localparam logic [2:0] NEG_OR  = 3'b101;
    localparam logic       NEG_ILL = 1'b0;
`else
    localparam logic [2:0] NEG_AND = 3'b010;
    localparam logic [2:0] NEG_OR  = 3'b010;
    localparam logic       NEG_ILL = 1'b1;
`endif

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic id_t mk_id(input logic v, input logic [1:0] op, input logic [5:0] fn,
                                  input logic src, input logic [31:0] r1, input logic [31:0] r2,
                                  input logic [31:0] imm);
        id_t d;
        d.v = v; d.op = op; d.fn = fn; d.src = src; d.r1 = r1; d.r2 = r2; d.imm = imm;
        return d;
    endfunction

    function automatic fw_t mk_fw(input logic [1:0] fa, input logic [1:0] fb,
                                  input logic [31:0] am, input logic [31:0] rw);
        fw_t f;
        f.fa = fa; f.fb = fb; f.am = am; f.rw = rw;
        return f;
    endfunction

    function automatic exp_t mk_ex(input string name, input logic v, input logic [2:0] ctrl,
                                   input logic ill, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] wd);
        exp_t e;
        e.name = name; e.v = v; e.ctrl = ctrl; e.ill = ill; e.a = a; e.b = b; e.wd = wd;
        return e;
    endfunction

    // One cycle: just after the edge, drive controls/ID/forwards and queue what EX should show now.
    task automatic step(input logic rst, input logic st, input logic fl, input id_t d,
                        input fw_t f, input logic chk, input exp_t e);
        @(posedge clk);
        #1;
        reset           = rst;
        bus.stall_e     = st;
        bus.flush_e     = fl;
        bus.valid_d     = d.v;
        bus.aluop_d     = d.op;
        bus.funct_d     = d.fn;
        bus.alusrc_d    = d.src;
        bus.rd1_d       = d.r1;
        bus.rd2_d       = d.r2;
        bus.signimm_d   = d.imm;
        bus.forwardae_e = f.fa;
        bus.forwardbe_e = f.fb;
        bus.aluout_m    = f.am;
        bus.result_w    = f.rw;
        if (chk) sb.push_back(e);
    endtask

    task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, req);
        end
    endtask

    // Monitor: pops one expectation per falling edge, away from the active edge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp(e.name, "valid_e",      {31'd0, bus.valid_e},      {31'd0, e.v});
            cmp(e.name, "alucontrol_e", {29'd0, bus.alucontrol_e}, {29'd0, e.ctrl});
            cmp(e.name, "illegal_e",    {31'd0, bus.illegal_e},    {31'd0, e.ill});
            cmp(e.name, "srca_e",       bus.srca_e,                e.a);
            cmp(e.name, "srcb_e",       bus.srcb_e,                e.b);
            cmp(e.name, "writedata_e",  bus.writedata_e,           e.wd);
        end
    end

    initial begin
        id_t  z;
        fw_t  f0;
        exp_t en;
        id_t  i_and;
        id_t  i_sub;
        z     = mk_id(1'b0, 2'b00, 6'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        f0    = mk_fw(2'b00, 2'b00, 32'd0, 32'd0);
        en    = mk_ex("none", 1'b0, 3'b010, 1'b0, 32'd0, 32'd0, 32'd0);
        i_sub = mk_id(1'b1, 2'b01, 6'd0, 1'b0, 32'h11, 32'h22, 32'd0);
        i_and = mk_id(1'b1, 2'b10, 6'b100100, 1'b0, 32'h33, 32'h44, 32'd0);

        reset = 1'b1;
        bus.stall_e = 1'b0; bus.flush_e = 1'b0; bus.valid_d = 1'b0;
        bus.aluop_d = 2'b00; bus.funct_d = 6'd0; bus.alusrc_d = 1'b0;
        bus.rd1_d = 32'd0; bus.rd2_d = 32'd0; bus.signimm_d = 32'd0;
        bus.forwardae_e = 2'b00; bus.forwardbe_e = 2'b00;
        bus.aluout_m = 32'd0; bus.result_w = 32'd0;

        step(1'b1, 1'b0, 1'b0, z, f0, 1'b0, en);
        step(1'b0, 1'b0, 1'b0, z, f0, 1'b1,
             mk_ex("reset", 1'b0, 3'b010, 1'b0, 32'd0, 32'd0, 32'd0));
        step(1'b0, 1'b0, 1'b0, mk_id(1'b1, 2'b10, 6'b101010, 1'b0, 32'd5, 32'd9, 32'd0), f0, 1'b1,
             mk_ex("empty", 1'b0, 3'b010, 1'b0, 32'd0, 32'd0, 32'd0));
        step(1'b0, 1'b0, 1'b0, mk_id(1'b1, 2'b00, 6'd0, 1'b1, 32'd3, 32'd7, 32'hFFFF_FFFC), f0, 1'b1,
             mk_ex("slt", 1'b1, 3'b111, 1'b0, 32'd5, 32'd9, 32'd9));
        step(1'b0, 1'b1, 1'b0, i_sub, f0, 1'b1,
             mk_ex("addi", 1'b1, 3'b010, 1'b0, 32'd3, 32'hFFFF_FFFC, 32'd7));
        step(1'b0, 1'b0, 1'b0, i_sub, mk_fw(2'b00, 2'b10, 32'h0000_1234, 32'd0), 1'b1,
             mk_ex("fwd_b_m", 1'b1, 3'b010, 1'b0, 32'd3, 32'hFFFF_FFFC, 32'h0000_1234));
        step(1'b0, 1'b1, 1'b0, i_and, f0, 1'b1,
             mk_ex("sub", 1'b1, 3'b110, 1'b0, 32'h11, 32'h22, 32'h22));
        step(1'b0, 1'b1, 1'b0, i_and, f0, 1'b1,
             mk_ex("stall1", 1'b1, 3'b110, 1'b0, 32'h11, 32'h22, 32'h22));
        step(1'b0, 1'b1, 1'b0, i_and, f0, 1'b1,
             mk_ex("stall2", 1'b1, 3'b110, 1'b0, 32'h11, 32'h22, 32'h22));
        step(1'b0, 1'b0, 1'b0, i_and, f0, 1'b1,
             mk_ex("stall3", 1'b1, 3'b110, 1'b0, 32'h11, 32'h22, 32'h22));
        step(1'b0, 1'b1, 1'b1, mk_id(1'b1, 2'b11, 6'd0, 1'b0, 32'h99, 32'h98, 32'd0), f0, 1'b1,
             mk_ex("and", 1'b1, 3'b000, 1'b0, 32'h33, 32'h44, 32'h44));
        step(1'b0, 1'b0, 1'b0, mk_id(1'b1, 2'b10, 6'b110100, 1'b0, 32'd0, 32'd0, 32'd0),
             mk_fw(2'b01, 2'b00, 32'd0, 32'hAAAA_5555), 1'b1,
             mk_ex("flush_stall", 1'b0, 3'b010, 1'b0, 32'hAAAA_5555, 32'd0, 32'd0));
        step(1'b0, 1'b0, 1'b0, mk_id(1'b0, 2'b10, 6'b110100, 1'b0, 32'd0, 32'd0, 32'd0), f0, 1'b1,
             mk_ex("neg_and", 1'b1, NEG_AND, NEG_ILL, 32'd0, 32'd0, 32'd0));
        step(1'b0, 1'b0, 1'b0, mk_id(1'b1, 2'b10, 6'b110101, 1'b1, 32'h55, 32'd0, 32'h66), f0, 1'b1,
             mk_ex("neg_invalid", 1'b0, 3'b010, 1'b0, 32'd0, 32'd0, 32'd0));
        step(1'b0, 1'b0, 1'b0, mk_id(1'b1, 2'b10, 6'b000000, 1'b0, 32'd1, 32'd2, 32'd0), f0, 1'b1,
             mk_ex("neg_or", 1'b1, NEG_OR, NEG_ILL, 32'h55, 32'h66, 32'd0));
        step(1'b0, 1'b0, 1'b0, mk_id(1'b1, 2'b11, 6'd0, 1'b0, 32'd4, 32'd5, 32'd0), f0, 1'b1,
             mk_ex("illegal", 1'b1, 3'b010, 1'b1, 32'd1, 32'd2, 32'd2));
        step(1'b0, 1'b0, 1'b0, mk_id(1'b1, 2'b10, 6'b100101, 1'b0, 32'h77, 32'h78, 32'd0), f0, 1'b1,
             mk_ex("ori", 1'b1, 3'b001, 1'b0, 32'd4, 32'd5, 32'd5));
        step(1'b0, 1'b0, 1'b0, mk_id(1'b1, 2'b10, 6'b100000, 1'b0, 32'h10, 32'h20, 32'd0),
             mk_fw(2'b11, 2'b01, 32'h0000_DEAD, 32'h0000_BEEF), 1'b1,
             mk_ex("or_fwd11", 1'b1, 3'b001, 1'b0, 32'h77, 32'h0000_BEEF, 32'h0000_BEEF));
        step(1'b0, 1'b0, 1'b0, mk_id(1'b1, 2'b10, 6'b100010, 1'b0, 32'h30, 32'h40, 32'd0), f0, 1'b1,
             mk_ex("add_r", 1'b1, 3'b010, 1'b0, 32'h10, 32'h20, 32'h20));
        step(1'b1, 1'b0, 1'b0, mk_id(1'b1, 2'b01, 6'd0, 1'b0, 32'h50, 32'h60, 32'd0), f0, 1'b1,
             mk_ex("sub_r", 1'b1, 3'b110, 1'b0, 32'h30, 32'h40, 32'h40));
        step(1'b0, 1'b0, 1'b0, z, f0, 1'b1,
             mk_ex("mid_reset", 1'b0, 3'b010, 1'b0, 32'd0, 32'd0, 32'd0));
        step(1'b0, 1'b0, 1'b0, z, f0, 1'b1,
             mk_ex("post_reset", 1'b0, 3'b010, 1'b0, 32'd0, 32'd0, 32'd0));

        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
        #1;
        n_total++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX issue stage that drives the ALU's input interface: decodes aluop/funct into the 3-bit alucontrol code and registers operands across the ID->EX boundary.
- Resolves EX-stage operand forwarding and the immediate select, so the ALU receives final srca/srcb.
- Sits between the decode stage and the ALU in the pipelined MIPS datapath.
- Honours hazard-unit stall and flush.

Parameters:
N, 32, datapath width of operands and forwarded results

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
stall_e  input  1  hold EX register contents
flush_e  input  1  load bubble into EX register
valid_d  input  1  ID-stage instruction valid
aluop_d  input  2  main-decoder ALU op class
funct_d  input  6  R-type funct field
alusrc_d  input  1  1 = srcb takes sign-extended immediate
rd1_d  input  N  register file read data 1
rd2_d  input  N  register file read data 2
signimm_d  input  N  sign-extended immediate
forwardae_e  input  2  srca forward select (EX-stage timing)
forwardbe_e  input  2  srcb/writedata forward select
aluout_m  input  N  MEM-stage ALU result
result_w  input  N  WB-stage result
valid_e  output  1  EX instruction valid
alucontrol_e  output  3  ALU operation code
srca_e  output  N  final ALU operand A
srcb_e  output  N  final ALU operand B
writedata_e  output  N  forwarded rd2 for stores
illegal_e  output  1  EX instruction had unsupported aluop/funct

Behaviour:
- Decode (combinational in ID, then registered):
  - aluop 00 -> 010 (add).
  - aluop 01 -> 110 (sub).
  - aluop 11 -> 001 (or, ori).
  - aluop 10 -> decode funct:
    - 100000 -> 010
    - 100010 -> 110
    - 100100 -> 000
    - 100101 -> 001
    - 101010 -> 111 (slt)
    - any other funct -> illegal: alucontrol 010, illegal flag 1.
- The illegal flag is captured only when valid_d=1. An invalid slot captures illegal 0 and alucontrol 010.
- EX register holds: valid, alucontrol, illegal, alusrc, rd1, rd2, signimm.
- Update priority on rising clk: reset > flush_e > stall_e > load.
  - reset or flush_e: valid_e 0, alucontrol_e 010, illegal_e 0, alusrc 0, all data regs 0 (bubble). flush_e with stall_e together -> bubble.
  - stall_e alone: all EX regs hold.
  - Otherwise: load ID values.
- Latency: ID inputs appear at EX outputs exactly 1 cycle after the capturing edge. No back-pressure beyond stall_e.
- Reset mid-stream discards the in-flight EX instruction; outputs take reset values in the following cycle.
- Forward muxes (combinational from registered state and current forward inputs):
  - Select 00 -> registered rd; 01 -> result_w; 10 -> aluout_m; 11 -> registered rd (treated as 00).
  - srca_e = forward mux on rd1.
  - writedata_e = forward mux on rd2.
  - srcb_e = alusrc ? signimm reg : writedata_e.
- Forward selects and aluout_m/result_w are not registered. Changing them during stall changes srca_e/srcb_e in the same cycle.
- All widths N. No arithmetic performed; pure selection and decode.

Optional Feature:
- Macro ALU_NEGOPS_EN.
- Defined: aluop 10 additionally decodes funct 110100 -> 100 (and with inverted B) and funct 110101 -> 101 (or with inverted B); neither is illegal.
- Undefined: both funct codes are illegal (alucontrol 010, illegal_e 1 when valid). ALU codes 100/101 are never issued.

Test Plan:
- Reset held 2 cycles, then released with flush/stall 0 and valid_d 0 -> valid_e 0, alucontrol_e 010, illegal_e 0, srca_e/srcb_e/writedata_e 0.
- valid_d 1, aluop 10, funct 101010, rd1 5, rd2 9, forward selects 00, alusrc 0 -> next cycle: alucontrol_e 111, srca_e 5, srcb_e 9, valid_e 1.
- aluop 00, alusrc 1, signimm FFFFFFFC, rd2 7 -> next cycle: srcb_e FFFFFFFC, writedata_e 7, alucontrol_e 010. Then set forwardbe 10 with aluout_m 0000_1234 -> writedata_e 0000_1234, srcb_e still FFFFFFFC.
- Load sub (aluop 01), then assert stall_e 3 cycles while ID presents an and (aluop 10, funct 100100) -> alucontrol_e stays 110 for all 3 cycles. Deassert stall_e -> next cycle 000.
- stall_e and flush_e both 1 with valid instruction in EX -> next cycle valid_e 0, alucontrol_e 010. forwardae 01 with result_w AAAA5555 -> srca_e AAAA5555 combinationally.
- aluop 10, funct 110100, valid 1 -> with ALU_NEGOPS_EN: alucontrol_e 100, illegal_e 0. Without it: alucontrol_e 010, illegal_e 1. Same funct with valid_d 0 -> illegal_e 0.
